// File: rtl/pixel_combinator.sv
// pixel_combinator: merges per-engine pixel queues into one raster-ordered ready/valid stream.
// Optional SCAN timeout is built only when PIXEL_COMBINATOR_TIMEOUT_EN is defined.
module pixel_combinator #(
  parameter int NUM_ENGINES    = 4,
  parameter int DATA_WIDTH     = 10,
  parameter int RBG_SIZE       = 24,
  parameter int IMAGE_W        = 640,
  parameter int IMAGE_H        = 480,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_ENGINES-1:0]          match_i,
  input  logic [NUM_ENGINES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]           xpixel_check,
  output logic [DATA_WIDTH-1:0]           ypixel_check,
  output logic [RBG_SIZE-1:0]             stream_data,
  output logic                            stream_valid,
  input  logic                            stream_ready,
  output logic                            stream_sop,
  output logic                            stream_eop,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            sim_match_err,
  output logic                            timeout_err
);

  localparam int SEL_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_SEND    = 2'd3;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_x;
  logic [DATA_WIDTH-1:0] r_y;
  logic [SEL_W-1:0]      r_sel;
  logic [RBG_SIZE-1:0]   r_data;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_match_err;

  logic [SEL_W-1:0]      w_sel;
  logic                  w_any;
  logic                  w_multi;
  logic [RBG_SIZE-1:0]   w_colour;
  logic                  w_last_x;
  logic                  w_last_y;
  logic                  w_first;

`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_timeout_err;
  logic             w_tmo_hit;
  assign w_tmo_hit   = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // Lowest set match bit wins; any second set bit flags a simultaneous match.
  always_comb begin
    w_sel   = '0;
    w_any   = 1'b0;
    w_multi = 1'b0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (match_i[k]) begin
        if (w_any) w_multi = 1'b1;
        else       w_sel   = SEL_W'(k);
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_colour = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (r_sel == SEL_W'(k)) w_colour = colour_i[k*RBG_SIZE +: RBG_SIZE];
    end
  end

  assign w_last_x = (r_x == DATA_WIDTH'(IMAGE_W - 1));
  assign w_last_y = (r_y == DATA_WIDTH'(IMAGE_H - 1));
  assign w_first  = (r_x == '0) && (r_y == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_sel         <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_sop         <= 1'b0;
      r_eop         <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_match_err   <= 1'b0;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_SCAN;
            r_x         <= '0;
            r_y         <= '0;
            r_busy      <= 1'b1;
            r_match_err <= 1'b0;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
`endif
          end
        end
        ST_SCAN: begin
          if (w_any) begin
            r_sel   <= w_sel;
            r_state <= ST_CAPTURE;
            if (w_multi) r_match_err <= 1'b1;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
          end else if (w_tmo_hit) begin
            // No engine produced this pixel: emit a black pixel and move on.
            r_data        <= '0;
            r_valid       <= 1'b1;
            r_sop         <= w_first;
            r_eop         <= w_last_x && w_last_y;
            r_timeout_err <= 1'b1;
            r_state       <= ST_SEND;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
`endif
          end
        end
        ST_CAPTURE: begin
          r_data  <= w_colour;
          r_valid <= 1'b1;
          r_sop   <= w_first;
          r_eop   <= w_last_x && w_last_y;
          r_state <= ST_SEND;
        end
        default: begin
          if (stream_ready) begin
            r_valid <= 1'b0;
`ifdef PIXEL_COMBINATOR_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
            if (w_last_x && w_last_y) begin
              r_x          <= '0;
              r_y          <= '0;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
              r_state      <= ST_IDLE;
            end else if (w_last_x) begin
              r_x     <= '0;
              r_y     <= r_y + DATA_WIDTH'(1);
              r_state <= ST_SCAN;
            end else begin
              r_x     <= r_x + DATA_WIDTH'(1);
              r_state <= ST_SCAN;
            end
          end
        end
      endcase
    end
  end

  assign xpixel_check  = r_x;
  assign ypixel_check  = r_y;
  assign stream_data   = r_data;
  assign stream_valid  = r_valid;
  assign stream_sop    = r_sop;
  assign stream_eop    = r_eop;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;
  assign sim_match_err = r_match_err;

endmodule
